// File: rtl/nmr_pulse_pkg.sv
// Shared FSM encoding and helpers for the NMR burst square-wave generator.
package nmr_pulse_pkg;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_HIGH = 2'd1,
    ST_LOW  = 2'd2
  } state_t;

  // Widest length word the clamp helper handles; callers zero-extend into it.
  localparam int MAX_CNT_WIDTH = 64;

  // A zero-length phase still emits one beat.
  function automatic logic [MAX_CNT_WIDTH-1:0] clamp_len(input logic [MAX_CNT_WIDTH-1:0] x);
    return (x == '0) ? MAX_CNT_WIDTH'(1) : x;
  endfunction

endpackage

// File: rtl/pulse_phase_counter.sv
// Loadable down-counter for one high/low phase; o_last flags the final beat.
module pulse_phase_counter #(
  parameter int CNT_WIDTH = 32
) (
  input  logic                 aclk,
  input  logic                 aresetn,
  input  logic                 i_load,
  input  logic [CNT_WIDTH-1:0] i_value,
  input  logic                 i_en,
  output logic                 o_last
);

  logic [CNT_WIDTH-1:0] r_count;

  // NOTE: state is written with <= so every register samples pre-edge values.
  always_ff @(posedge aclk) begin
    if (!aresetn) begin
      r_count <= '0;
    end else if (i_load) begin
      r_count <= i_value;
    end else if (i_en) begin
      r_count <= r_count - CNT_WIDTH'(1);
    end
  end

  assign o_last = (r_count == CNT_WIDTH'(1));

endmodule

// File: rtl/nmr_pulse_generator.sv
// Burst square-wave generator driving one DAC channel over AXI-Stream.
// State, counters and tdata advance only on accepted beats.
module nmr_pulse_generator
  import nmr_pulse_pkg::*;
#(
  parameter int AXIS_DATA_WIDTH_OUT = 14,
  parameter int CNT_WIDTH           = 32
) (
  input  logic                           aclk,
  input  logic                           aresetn,
  input  logic [CNT_WIDTH-1:0]           cfg_high_len,
  input  logic [CNT_WIDTH-1:0]           cfg_low_len,
  input  logic [CNT_WIDTH-1:0]           cfg_num_cycles,
  input  logic [AXIS_DATA_WIDTH_OUT-1:0] cfg_level_high,
  input  logic [AXIS_DATA_WIDTH_OUT-1:0] cfg_level_low,
  input  logic [AXIS_DATA_WIDTH_OUT-1:0] cfg_level_idle,
  input  logic                           start,
  input  logic                           stop,
  output logic                           busy,
  output logic                           done,
  input  logic                           m_axis_tready,
  output logic [AXIS_DATA_WIDTH_OUT-1:0] m_axis_tdata,
  output logic                           m_axis_tvalid
);

  state_t                         r_state, w_state_nxt;
  logic                           r_start_pend, r_stop_pend, r_busy, r_done, r_tvalid;
  logic [AXIS_DATA_WIDTH_OUT-1:0] r_tdata, w_data_nxt;
  logic [CNT_WIDTH-1:0]           r_cycles;
  logic [CNT_WIDTH-1:0]           r_high_len, r_low_len, r_num_cycles;
  logic [AXIS_DATA_WIDTH_OUT-1:0] r_lvl_high, r_lvl_low, r_lvl_idle;

  logic                           w_beat, w_start_acc, w_stop_acc, w_finite, w_last;
  logic                           w_phase_load, w_phase_en, w_cyc_load, w_cyc_dec, w_end;
  logic [CNT_WIDTH-1:0]           w_phase_val, w_high_len_c, w_low_len_c;

  assign w_beat       = r_tvalid & m_axis_tready;
  // Stop beats a simultaneous start; neither start nor stop acts on the wrong busy state.
  assign w_start_acc  = start & ~stop & ~r_busy;
  assign w_stop_acc   = stop & r_busy;
  assign w_finite     = (r_num_cycles != '0);
  assign w_high_len_c = CNT_WIDTH'(clamp_len(MAX_CNT_WIDTH'(r_high_len)));
  assign w_low_len_c  = CNT_WIDTH'(clamp_len(MAX_CNT_WIDTH'(r_low_len)));

  pulse_phase_counter #(
    .CNT_WIDTH(CNT_WIDTH)
  ) u_phase_cnt (
    .aclk    (aclk),
    .aresetn (aresetn),
    .i_load  (w_phase_load),
    .i_value (w_phase_val),
    .i_en    (w_phase_en),
    .o_last  (w_last)
  );

  // NOTE: every always_comb output is defaulted first so no path infers a latch.
  always_comb begin
    w_state_nxt  = r_state;
    w_phase_load = 1'b0;
    w_phase_val  = w_high_len_c;
    w_phase_en   = 1'b0;
    w_cyc_load   = 1'b0;
    w_cyc_dec    = 1'b0;
    w_end        = 1'b0;

    if (w_beat) begin
      if (r_stop_pend) begin
        w_state_nxt = ST_IDLE;
        w_end       = 1'b1;
      end else begin
        case (r_state)
          ST_IDLE: begin
            if (r_start_pend) begin
              w_state_nxt  = ST_HIGH;
              w_phase_load = 1'b1;
              w_cyc_load   = 1'b1;
            end
          end
          ST_HIGH: begin
            if (w_last) begin
              w_state_nxt  = ST_LOW;
              w_phase_load = 1'b1;
              w_phase_val  = w_low_len_c;
            end else begin
              w_phase_en = 1'b1;
            end
          end
          ST_LOW: begin
            if (w_last) begin
              w_cyc_dec = w_finite;
              if (w_finite && (r_cycles == CNT_WIDTH'(1))) begin
                w_state_nxt = ST_IDLE;
                w_end       = 1'b1;
              end else begin
                w_state_nxt  = ST_HIGH;
                w_phase_load = 1'b1;
              end
            end else begin
              w_phase_en = 1'b1;
            end
          end
          default: w_state_nxt = ST_IDLE;
        endcase
      end
    end

    // tdata is the level of the state being entered; the burst's own idle code is used on exit.
    case (w_state_nxt)
      ST_HIGH: w_data_nxt = r_lvl_high;
      ST_LOW:  w_data_nxt = r_lvl_low;
      default: w_data_nxt = r_busy ? r_lvl_idle : cfg_level_idle;
    endcase
  end

  always_ff @(posedge aclk) begin
    if (!aresetn) begin
      r_state      <= ST_IDLE;
      r_start_pend <= 1'b0;
      r_stop_pend  <= 1'b0;
      r_busy       <= 1'b0;
      r_done       <= 1'b0;
      r_tvalid     <= 1'b0;
      r_tdata      <= '0;
      r_cycles     <= '0;
      r_high_len   <= '0;
      r_low_len    <= '0;
      r_num_cycles <= '0;
      r_lvl_high   <= '0;
      r_lvl_low    <= '0;
      r_lvl_idle   <= '0;
    end else begin
      r_state  <= w_state_nxt;
      r_done   <= w_end;
      r_tvalid <= 1'b1;
      if (!r_tvalid || m_axis_tready) r_tdata <= w_data_nxt;

      if (w_end)            r_busy <= 1'b0;
      else if (w_start_acc) r_busy <= 1'b1;

      if (w_end || w_cyc_load) r_start_pend <= 1'b0;
      else if (w_start_acc)    r_start_pend <= 1'b1;

      if (w_end)           r_stop_pend <= 1'b0;
      else if (w_stop_acc) r_stop_pend <= 1'b1;

      if (w_cyc_load)     r_cycles <= r_num_cycles;
      else if (w_cyc_dec) r_cycles <= r_cycles - CNT_WIDTH'(1);

      if (w_start_acc) begin
        r_high_len   <= cfg_high_len;
        r_low_len    <= cfg_low_len;
        r_num_cycles <= cfg_num_cycles;
        r_lvl_high   <= cfg_level_high;
        r_lvl_low    <= cfg_level_low;
        r_lvl_idle   <= cfg_level_idle;
      end
    end
  end

  assign busy          = r_busy;
  assign done          = r_done;
  assign m_axis_tvalid = r_tvalid;
  assign m_axis_tdata  = r_tdata;

endmodule

// File: tb/tb_nmr_pulse_generator.sv
// Directed bench for nmr_pulse_generator: a beat scoreboard fed at stimulus time
// and drained by a negedge monitor, plus cycle-exact busy/done/reset checks.
module tb_nmr_pulse_generator;

  localparam int DW = 14;
  localparam int CW = 32;
  localparam logic [DW-1:0] LVL_H = 14'h0FA0;
  localparam logic [DW-1:0] LVL_L = 14'h3060;
  localparam logic [DW-1:0] LVL_I = 14'h0010;
  localparam logic [DW-1:0] ALT_H = 14'h1111;
  localparam logic [DW-1:0] ALT_L = 14'h2222;

  logic          aclk = 1'b0;
  logic          aresetn;
  logic [CW-1:0] cfg_high_len, cfg_low_len, cfg_num_cycles;
  logic [DW-1:0] cfg_level_high, cfg_level_low, cfg_level_idle;
  logic          start, stop, busy, done;
  logic          m_axis_tready, m_axis_tvalid;
  logic [DW-1:0] m_axis_tdata;

  logic [DW-1:0] exp_q[$];
  int            n_checks = 0;
  int            n_pass   = 0;
  int            n_fail   = 0;
  int            done_cnt = 0;
  int            done_base;

  always #5 aclk = ~aclk;

  nmr_pulse_generator #(
    .AXIS_DATA_WIDTH_OUT(DW),
    .CNT_WIDTH          (CW)
  ) dut (
    .aclk          (aclk),
    .aresetn       (aresetn),
    .cfg_high_len  (cfg_high_len),
    .cfg_low_len   (cfg_low_len),
    .cfg_num_cycles(cfg_num_cycles),
    .cfg_level_high(cfg_level_high),
    .cfg_level_low (cfg_level_low),
    .cfg_level_idle(cfg_level_idle),
    .start         (start),
    .stop          (stop),
    .busy          (busy),
    .done          (done),
    .m_axis_tready (m_axis_tready),
    .m_axis_tdata  (m_axis_tdata),
    .m_axis_tvalid (m_axis_tvalid)
  );

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) n_pass++;
    else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Monitor: compares accepted beats against the scoreboard and holds tdata under stalls.
  initial begin
    logic          prev_stall;
    logic [DW-1:0] prev_data;
    logic [DW-1:0] e;
    prev_stall = 1'b0;
    prev_data  = '0;
    forever begin
      @(negedge aclk);
      if (aresetn) begin
        if (done) done_cnt++;
        if (prev_stall) check("stall_stable", m_axis_tdata, prev_data);
        if (m_axis_tvalid && m_axis_tready && exp_q.size() > 0) begin
          e = exp_q.pop_front();
          check("beat", m_axis_tdata, e);
        end
      end
      prev_stall = aresetn && m_axis_tvalid && !m_axis_tready;
      prev_data  = m_axis_tdata;
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation exceeded time limit");
    $fatal(1, "watchdog");
  end

  task automatic tick();
    @(posedge aclk);
    #1;
  endtask

  task automatic set_cfg(input int h, input int l, input int n,
                         input logic [DW-1:0] lh, input logic [DW-1:0] ll);
    cfg_high_len   = CW'(h);
    cfg_low_len    = CW'(l);
    cfg_num_cycles = CW'(n);
    cfg_level_high = lh;
    cfg_level_low  = ll;
  endtask

  // Reference sequence of accepted beats for a finite burst with the default levels.
  task automatic push_burst(input int h, input int l, input int n);
    int hh;
    int ll;
    hh = (h == 0) ? 1 : h;
    ll = (l == 0) ? 1 : l;
    exp_q.push_back(LVL_I);
    for (int c = 0; c < n; c++) begin
      repeat (hh) exp_q.push_back(LVL_H);
      repeat (ll) exp_q.push_back(LVL_L);
    end
    exp_q.push_back(LVL_I);
  endtask

  task automatic pulse_start();
    start = 1'b1;
    tick();
    start = 1'b0;
  endtask

  task automatic wait_drain(input int budget, input bit rnd);
    int k;
    k = 0;
    while (exp_q.size() > 0 && k < budget) begin
      tick();
      if (rnd) m_axis_tready = 1'($urandom_range(0, 1));
      k++;
    end
    if (exp_q.size() > 0) begin
      check("drain_timeout", exp_q.size(), 0);
      exp_q.delete();
    end
    m_axis_tready = 1'b1;
  endtask

  initial begin
    aresetn        = 1'b0;
    start          = 1'b0;
    stop           = 1'b0;
    m_axis_tready  = 1'b1;
    cfg_level_idle = LVL_I;
    set_cfg(3, 2, 2, LVL_H, LVL_L);

    // Reset values and release behaviour.
    repeat (3) tick();
    check("rst_tvalid", m_axis_tvalid, 1'b0);
    check("rst_tdata", m_axis_tdata, '0);
    check("rst_busy", busy, 1'b0);
    check("rst_done", done, 1'b0);
    aresetn = 1'b1;
    tick();
    check("rel_tvalid", m_axis_tvalid, 1'b1);
    check("rel_tdata", m_axis_tdata, LVL_I);
    repeat (2) tick();

    // Basic burst 3/2/2 with cycle-exact busy and done.
    done_base = done_cnt;
    pulse_start();
    push_burst(3, 2, 2);
    for (int k = 0; k < 12; k++) begin
      check("t1_busy", busy, (k < 11));
      check("t1_done", done, (k == 11));
      tick();
    end
    check("t1_drained", exp_q.size(), 0);
    check("t1_done_cnt", done_cnt - done_base, 1);
    repeat (3) tick();

    // Same burst under random backpressure.
    done_base = done_cnt;
    m_axis_tready = 1'($urandom_range(0, 1));
    pulse_start();
    push_burst(3, 2, 2);
    wait_drain(400, 1'b1);
    repeat (2) tick();
    check("t2_done_cnt", done_cnt - done_base, 1);
    check("t2_busy", busy, 1'b0);

    // Continuous 1/1 alternation, then stop.
    set_cfg(1, 1, 0, LVL_H, LVL_L);
    done_base = done_cnt;
    pulse_start();
    exp_q.push_back(LVL_I);
    for (int i = 0; i < 100; i++) exp_q.push_back((i % 2 == 0) ? LVL_H : LVL_L);
    wait_drain(400, 1'b0);
    check("t3_busy_run", busy, 1'b1);
    stop = 1'b1;
    tick();
    stop = 1'b0;
    check("t3_stop_pend_done", done, 1'b0);
    check("t3_stop_pend_busy", busy, 1'b1);
    tick();
    check("t3_stop_idle", m_axis_tdata, LVL_I);
    check("t3_stop_done", done, 1'b1);
    check("t3_stop_busy", busy, 1'b0);
    tick();
    check("t3_done_drop", done, 1'b0);
    repeat (3) tick();
    check("t3_done_cnt", done_cnt - done_base, 1);

    // Zero lengths clamp to one beat each.
    set_cfg(0, 0, 1, LVL_H, LVL_L);
    done_base = done_cnt;
    pulse_start();
    push_burst(0, 0, 1);
    wait_drain(50, 1'b0);
    repeat (2) tick();
    check("t4_done_cnt", done_cnt - done_base, 1);

    // Start while busy with new config is ignored.
    set_cfg(2, 1, 1, LVL_H, LVL_L);
    done_base = done_cnt;
    pulse_start();
    push_burst(2, 1, 1);
    set_cfg(5, 5, 3, ALT_H, ALT_L);
    pulse_start();
    wait_drain(100, 1'b0);
    repeat (20) tick();
    check("t5_busy", busy, 1'b0);
    check("t5_tdata", m_axis_tdata, LVL_I);
    check("t5_done_cnt", done_cnt - done_base, 1);

    // Start and stop together: nothing happens.
    set_cfg(3, 2, 2, LVL_H, LVL_L);
    done_base = done_cnt;
    start = 1'b1;
    stop  = 1'b1;
    tick();
    start = 1'b0;
    stop  = 1'b0;
    check("t6_busy", busy, 1'b0);
    repeat (10) tick();
    check("t6_busy_late", busy, 1'b0);
    check("t6_tdata", m_axis_tdata, LVL_I);
    check("t6_done_cnt", done_cnt - done_base, 0);

    // Reset during HIGH, then recovery.
    set_cfg(10, 2, 1, LVL_H, LVL_L);
    done_base = done_cnt;
    pulse_start();
    repeat (3) tick();
    check("t7_in_high", m_axis_tdata, LVL_H);
    aresetn = 1'b0;
    tick();
    check("t7_rst_tvalid", m_axis_tvalid, 1'b0);
    check("t7_rst_tdata", m_axis_tdata, '0);
    check("t7_rst_busy", busy, 1'b0);
    check("t7_rst_done", done, 1'b0);
    aresetn = 1'b1;
    tick();
    check("t7_rel_tvalid", m_axis_tvalid, 1'b1);
    check("t7_rel_tdata", m_axis_tdata, LVL_I);
    repeat (20) tick();
    check("t7_lost_done", done_cnt - done_base, 0);
    set_cfg(3, 2, 2, LVL_H, LVL_L);
    pulse_start();
    push_burst(3, 2, 2);
    wait_drain(100, 1'b0);
    repeat (2) tick();
    check("t7_after_done_cnt", done_cnt - done_base, 1);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
